seg_scan_decoder: RTL and testbench

//  Receive-side monitor for the multiplexed 4-digit seven-segment interface (AN/SEGMENT) driven
//  by the display scanner. Samples the scanned anode/segment lines and rebuilds the shown
//  16-bit hex value, decimal points and error flags. Used in benches and on-chip self-check to

---
 rtl/seg_scan_decoder_if.sv | 37 +++
 rtl/seg_scan_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder_if
// Bundles the scanned seven-segment lines and the rebuilt-frame readback for the
// seg_scan_decoder monitor.
//   master : the side driving the display lines (scanner model / bench); it
//            drives AN/SEGMENT and observes the decoded frame.
//   slave  : the decoder; it samples AN/SEGMENT and drives the frame outputs.
// Signals:
//   AN[3:0]       anode enables, active-low, one digit low at a time
//   SEGMENT[7:0]  segments, active-low, [0]=a .. [6]=g, [7]=dp
//   value[15:0]   last complete frame, digit n in value[4n+3:4n]
//   dp[3:0]       last complete frame decimal points, 1 = lit
//   frame_valid   one-cycle pulse when value/dp/frame_err update
//   frame_err     last frame held an undecodable segment pattern
//   an_err        sticky multi-hot anode flag
//   stalled       no digit accepted for TIMEOUT cycles
// -----------------------------------------------------------------------------
interface seg_scan_decoder_if;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        frame_err;
  logic        an_err;
  logic        stalled;

  modport master (
    output AN, SEGMENT,
    input  value, dp, frame_valid, frame_err, an_err, stalled
  );

  modport slave (
    input  AN, SEGMENT,
    output value, dp, frame_valid, frame_err, an_err, stalled
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Receive-side monitor for a multiplexed 4-digit seven-segment display. Samples
// the scanned anode/segment lines, waits for each digit to sit still for
// STABLE_CYCLES samples, decodes it back to a hex nibble and assembles the four
// digits into a frame. Flags undecodable patterns, multi-hot anodes and a scan
// that has stopped delivering digits.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of seg_scan_decoder_if (AN/SEGMENT in, frame out)
// Parameters:
//   STABLE_CYCLES  identical consecutive samples needed to accept a digit (>=2)
//   TIMEOUT        cycles without an accepted digit before 'stalled' is raised
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 8,
  parameter int TIMEOUT       = 1000000
) (
  input logic             clk,
  input logic             rst_n,
  seg_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  // Input synchroniser and one-cycle-delayed copy for the stability compare
  logic [3:0]    r_an_s1, r_an_s2, r_an_prev;
  logic [7:0]    r_seg_s1, r_seg_s2, r_seg_prev;

  logic [CW-1:0] r_stab_cnt;
  logic [IW-1:0] r_idle_cnt;

  // Frame assembly
  logic [3:0]    r_mask;
  logic [15:0]   r_shadow_val;
  logic [3:0]    r_shadow_dp;
  logic          r_shadow_err;

  // Registered outputs
  logic [15:0]   r_value;
  logic [3:0]    r_dp;
  logic          r_frame_valid;
  logic          r_frame_err;
  logic          r_an_err;
  logic          r_stalled;

  logic          w_blank;
  logic          w_idx_vld;
  logic [1:0]    w_idx;
  logic          w_same;
  logic          w_accept;
  logic          w_acc_digit;
  logic          w_acc_multi;
  logic [4:0]    w_dec;
  logic          w_complete;
  logic          w_timeout;
  logic [3:0]    w_mask_base;
  logic          w_err_base;
  logic [3:0]    w_mask_set;

  // {miss, nibble} for an active-high gfedcba pattern
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = 5'h00;
      7'h06:   res = 5'h01;
      7'h5B:   res = 5'h02;
      7'h4F:   res = 5'h03;
      7'h66:   res = 5'h04;
      7'h6D:   res = 5'h05;
      7'h7D:   res = 5'h06;
      7'h07:   res = 5'h07;
      7'h7F:   res = 5'h08;
      7'h6F:   res = 5'h09;
      7'h77:   res = 5'h0A;
      7'h7C:   res = 5'h0B;
      7'h39:   res = 5'h0C;
      7'h5E:   res = 5'h0D;
      7'h79:   res = 5'h0E;
      7'h71:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  always_comb begin
    w_idx     = 2'd0;
    w_idx_vld = 1'b0;
    case (r_an_s2)
      4'b1110: begin w_idx = 2'd0; w_idx_vld = 1'b1; end
      4'b1101: begin w_idx = 2'd1; w_idx_vld = 1'b1; end
      4'b1011: begin w_idx = 2'd2; w_idx_vld = 1'b1; end
      4'b0111: begin w_idx = 2'd3; w_idx_vld = 1'b1; end
      default: begin w_idx = 2'd0; w_idx_vld = 1'b0; end
    endcase
  end

  assign w_blank = (r_an_s2 == 4'b1111);
  assign w_same  = ({r_an_s2, r_seg_s2} == {r_an_prev, r_seg_prev});

  // The strobe fires on the edge where the counter steps onto STABLE_CYCLES;
  // once there the counter saturates so the same dwell cannot fire again.
  assign w_accept    = !w_blank && w_same && (r_stab_cnt == CW'(STABLE_CYCLES - 1));
  assign w_acc_digit = w_accept && w_idx_vld;
  assign w_acc_multi = w_accept && !w_idx_vld;

  assign w_dec      = f_decode(~r_seg_s2[6:0]);
  assign w_complete = (r_mask == 4'hF);
  assign w_timeout  = !w_acc_digit && (r_idle_cnt == IW'(TIMEOUT - 1));

  // Completion and timeout both drop the assembled state; an accept on the
  // same edge then seeds the next frame rather than being lost.
  assign w_mask_base = (w_complete || w_timeout) ? 4'h0 : r_mask;
  assign w_err_base  = (w_complete || w_timeout) ? 1'b0 : r_shadow_err;
  assign w_mask_set  = w_acc_digit ? (4'b0001 << w_idx) : 4'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_s1    <= 4'h0;
      r_an_s2    <= 4'h0;
      r_an_prev  <= 4'h0;
      r_seg_s1   <= 8'h00;
      r_seg_s2   <= 8'h00;
      r_seg_prev <= 8'h00;
    end else begin
      r_an_s1    <= bus.AN;
      r_an_s2    <= r_an_s1;
      r_an_prev  <= r_an_s2;
      r_seg_s1   <= bus.SEGMENT;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stab_cnt <= '0;
    end else if (w_blank) begin
      r_stab_cnt <= '0;
    end else if (!w_same) begin
      r_stab_cnt <= CW'(1);
    end else if (r_stab_cnt != CW'(STABLE_CYCLES)) begin
      r_stab_cnt <= r_stab_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (w_acc_digit) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != IW'(TIMEOUT)) begin
      r_idle_cnt <= r_idle_cnt + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask       <= 4'h0;
      r_shadow_val <= 16'h0000;
      r_shadow_dp  <= 4'h0;
      r_shadow_err <= 1'b0;
    end else begin
      r_mask       <= w_mask_base | w_mask_set;
      r_shadow_err <= w_err_base | (w_acc_digit & w_dec[4]);
      if (w_acc_digit) begin
        for (int i = 0; i < 4; i++) begin
          if (w_idx == 2'(i)) begin
            r_shadow_val[i*4 +: 4] <= w_dec[3:0];
            r_shadow_dp[i]         <= ~r_seg_s2[7];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value       <= 16'h0000;
      r_dp          <= 4'h0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_an_err      <= 1'b0;
      r_stalled     <= 1'b0;
    end else begin
      r_frame_valid <= w_complete;
      if (w_complete) begin
        r_value     <= r_shadow_val;
        r_dp        <= r_shadow_dp;
        r_frame_err <= r_shadow_err;
      end
      if (w_acc_multi) begin
        r_an_err <= 1'b1;
      end
      if (w_acc_digit) begin
        r_stalled <= 1'b0;
      end else if (w_timeout) begin
        r_stalled <= 1'b1;
      end
    end
  end

  assign bus.value       = r_value;
  assign bus.dp          = r_dp;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.an_err      = r_an_err;
  assign bus.stalled     = r_stalled;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
// Drives directed and randomized scan patterns into seg_scan_decoder
// (STABLE_CYCLES=4, TIMEOUT=64). A behavioural model reasons about the pin
// history as runs of identical samples and checks every output every cycle;
// directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;
  localparam int STABLE  = 4;
  localparam int TMO     = 64;
  localparam int QN      = STABLE + 4;

  logic clk;
  logic rst_n;

  seg_scan_decoder_if sif ();

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fv_count = 0;

  // gfedcba active-high glyphs for 0..F
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // ---------------- behavioural model ----------------
  logic [11:0] hist [$];
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic        m_fv, m_err, m_anerr, m_stalled;
  logic [3:0]  m_mask;
  logic [3:0]  m_sh_nib [4];
  logic [3:0]  m_sh_dp;
  logic        m_sh_err;
  int          m_idle;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < QN; i++) hist.push_back(12'h000);
    m_value = 0; m_dp = 0; m_fv = 0; m_err = 0; m_anerr = 0; m_stalled = 0;
    m_mask = 0; m_sh_dp = 0; m_sh_err = 0; m_idle = 0;
    for (int i = 0; i < 4; i++) m_sh_nib[i] = 0;
  endtask

  always @(posedge clk) begin
    logic [11:0] cur;
    logic [3:0]  an;
    logic [6:0]  lit;
    int          run, idx, nib;
    logic        acc, miss;
    if (!rst_n) begin
      model_reset();
    end else begin
      hist.push_back({sif.AN, sif.SEGMENT});
      if (hist.size() > QN) void'(hist.pop_front());
      // logic acts on the sample that went through two synchroniser flops
      cur = hist[hist.size()-3];
      run = 1;
      for (int i = hist.size() - 4; i >= 0; i--) begin
        if (hist[i] == cur) run++;
        else break;
      end
      an  = cur[11:8];
      acc = (run == STABLE) && (an != 4'hF);
      idx = -1;
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) idx = i;

      if (m_mask == 4'hF) begin
        for (int i = 0; i < 4; i++) m_value[i*4 +: 4] = m_sh_nib[i];
        m_dp = m_sh_dp; m_err = m_sh_err; m_fv = 1;
        m_mask = 0; m_sh_err = 0;
      end else begin
        m_fv = 0;
      end

      if (acc && idx >= 0) begin
        m_idle = 0;
        m_stalled = 0;
      end else if (m_idle < TMO) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_stalled = 1; m_mask = 0; m_sh_err = 0;
        end
      end

      if (acc && idx >= 0) begin
        lit = ~cur[6:0];
        nib = 0; miss = 1;
        for (int g = 0; g < 16; g++) if (glyph[g] == lit) begin nib = g; miss = 0; end
        m_sh_nib[idx] = 4'(nib);
        m_sh_dp[idx]  = ~cur[7];
        m_mask[idx]   = 1'b1;
        m_sh_err      = m_sh_err | miss;
      end else if (acc) begin
        m_anerr = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sif.frame_valid === 1'b1) fv_count++;
    chk("value",       sif.value,               m_value);
    chk("dp",          {12'h0, sif.dp},         {12'h0, m_dp});
    chk("frame_valid", {15'h0, sif.frame_valid}, {15'h0, m_fv});
    chk("frame_err",   {15'h0, sif.frame_err},  {15'h0, m_err});
    chk("an_err",      {15'h0, sif.an_err},     {15'h0, m_anerr});
    chk("stalled",     {15'h0, sif.stalled},    {15'h0, m_stalled});
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
    @(negedge clk);
    sif.AN = an;
    sif.SEGMENT = seg;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic scan_1234();
    hold(4'b1110, 8'h99, 20);
    hold(4'b1101, 8'hB0, 20);
    hold(4'b1011, 8'hA4, 20);
    hold(4'b0111, 8'hF9, 20);
  endtask

  int c0, lat;
  logic [3:0] ra;
  logic [6:0] rs;
  logic       rdp;
  int         ridx;

  initial begin
    rst_n = 1'b0;
    sif.AN = 4'($urandom);
    sif.SEGMENT = 8'($urandom);
    repeat (4) begin
      @(negedge clk);
      sif.AN = 4'($urandom);
      sif.SEGMENT = 8'($urandom);
    end
    // scenario 1: reset values, then idle blanking times out
    chk("rst_value", sif.value, 16'h0000);
    chk("rst_dp", {12'h0, sif.dp}, 16'h0);
    chk("rst_fv", {15'h0, sif.frame_valid}, 16'h0);
    chk("rst_ferr", {15'h0, sif.frame_err}, 16'h0);
    chk("rst_anerr", {15'h0, sif.an_err}, 16'h0);
    chk("rst_stalled", {15'h0, sif.stalled}, 16'h0);
    @(negedge clk);
    sif.AN = 4'hF; sif.SEGMENT = 8'hFF; rst_n = 1'b1;
    c0 = fv_count;
    repeat (60) @(negedge clk);
    chk("s1_not_yet_stalled", {15'h0, sif.stalled}, 16'h0);
    repeat (40) @(negedge clk);
    chk("s1_no_frame", 16'(fv_count - c0), 16'h0);
    chk("s1_stalled", {15'h0, sif.stalled}, 16'h1);

    // scenario 2: clean 1234 frame with latency measured on the last digit
    c0 = fv_count;
    hold(4'b1110, 8'h99, 20);
    hold(4'b1101, 8'hB0, 20);
    hold(4'b1011, 8'hA4, 20);
    @(negedge clk);
    sif.AN = 4'b0111; sif.SEGMENT = 8'hF9;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (sif.frame_valid === 1'b1 && lat < 0) lat = n;
    end
    chk("s2_latency", 16'(lat), 16'd7);
    chk("s2_frames", 16'(fv_count - c0), 16'd1);
    chk("s2_value", sif.value, 16'h1234);
    chk("s2_dp", {12'h0, sif.dp}, 16'h0);
    chk("s2_ferr", {15'h0, sif.frame_err}, 16'h0);
    chk("s2_stalled", {15'h0, sif.stalled}, 16'h0);

    // scenario 3: short glitch inside digit1 dwell
    c0 = fv_count;
    hold(4'b1110, 8'h99, 20);
    hold(4'b1101, 8'hB0, 8);
    hold(4'b1110, 8'h80, 3);
    hold(4'b1101, 8'hB0, 9);
    hold(4'b1011, 8'hA4, 20);
    hold(4'b0111, 8'hF9, 20);
    chk("s3_frames", 16'(fv_count - c0), 16'd1);
    chk("s3_value", sif.value, 16'h1234);

    // scenario 4: undecodable digit2, then a clean frame
    hold(4'b1110, 8'h99, 20);
    hold(4'b1101, 8'hB0, 20);
    hold(4'b1011, 8'hF6, 20);
    hold(4'b0111, 8'hF9, 20);
    chk("s4_ferr", {15'h0, sif.frame_err}, 16'h1);
    chk("s4_value", sif.value, 16'h1034);
    scan_1234();
    chk("s4_ferr_clear", {15'h0, sif.frame_err}, 16'h0);
    chk("s4_value_clean", sif.value, 16'h1234);

    // scenario 5: multi-hot anodes are sticky
    hold(4'b1100, 8'h99, 10);
    chk("s5_anerr", {15'h0, sif.an_err}, 16'h1);
    scan_1234();
    chk("s5_anerr_sticky", {15'h0, sif.an_err}, 16'h1);

    // scenario 6: reset mid-frame discards partial digits
    hold(4'b1110, 8'h99, 20);
    hold(4'b1101, 8'hB0, 20);
    @(negedge clk);
    rst_n = 1'b0; sif.AN = 4'hF; sif.SEGMENT = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("s6_anerr_reset", {15'h0, sif.an_err}, 16'h0);
    c0 = fv_count;
    hold(4'b1110, 8'hA1, 20);
    hold(4'b1101, 8'hC6, 20);
    hold(4'b1011, 8'h83, 20);
    hold(4'b0111, 8'h08, 20);
    chk("s6_frames", 16'(fv_count - c0), 16'd1);
    chk("s6_value", sif.value, 16'hABCD);
    chk("s6_dp", {12'h0, sif.dp}, 16'h0008);

    // randomized scanning: any order, glitches, bad glyphs, stray anodes, stalls
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        hold(4'hF, 8'hFF, $urandom_range(60, 75));
      end else if (r == 1) begin
        hold(4'($urandom), 8'($urandom), $urandom_range(1, 10));
      end else begin
        ridx = $urandom_range(0, 3);
        rs   = glyph[$urandom_range(0, 15)];
        if ($urandom_range(0, 9) == 0) rs = 7'($urandom);
        rdp  = 1'($urandom_range(0, 1));
        ra   = ~(4'b0001 << ridx);
        hold(ra, {~rdp, ~rs}, $urandom_range(1, 14));
      end
    end
    hold(4'hF, 8'hFF, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
